// File: rtl/matmul_datapath_if.sv
// Bundles the control word from control_unit, the memory ports and the status
// returned by the datapath. The master side drives the control word and memory read data.
interface matmul_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [3:0]        bus_ld;
    logic [12:0]       write_en;
    logic [1:0]        inc;
    logic [2:0]        clr;
    logic [3:0]        alu_mode;
    logic              dm_wr;
    logic              im_wr;
    logic              end_op;
    logic [DATA_W-1:0] dm_rdata;
    logic [DATA_W-1:0] im_rdata;

    logic [7:0]        ir;
    logic              z;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic [ADDR_W-1:0] im_addr;
    logic              im_we;
    logic              done;

    modport master (
        output bus_ld, write_en, inc, clr, alu_mode, dm_wr, im_wr, end_op,
               dm_rdata, im_rdata,
        input  ir, z, dm_addr, dm_wdata, dm_we, im_addr, im_we, done
    );

    modport slave (
        input  bus_ld, write_en, inc, clr, alu_mode, dm_wr, im_wr, end_op,
               dm_rdata, im_rdata,
        output ir, z, dm_addr, dm_wdata, dm_we, im_addr, im_we, done
    );
endinterface

// File: rtl/matmul_datapath.sv
// Datapath for the matrix-multiply processor: register file, bus mux, ALU,
// increment/clear logic, Z flag and the sticky end-of-program latch.
module matmul_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    matmul_datapath_if.slave   dp
);

    localparam int NREG  = 13;
    localparam int R_AR  = 0;
    localparam int R_PC  = 1;
    localparam int R_IR  = 2;
    localparam int R_DR  = 3;
    localparam int R_AC  = 4;
    localparam int R_R1  = 5;
    localparam int R_R2  = 6;
    localparam int R_R3  = 7;
    localparam int R_RI  = 8;
    localparam int R_RJ  = 9;
    localparam int R_RK  = 10;
    localparam int R_RN  = 11;
    localparam int R_TR  = 12;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    typedef enum logic [3:0] {
        ALU_PASS = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_MUL  = 4'd3,
        ALU_INC  = 4'd4,
        ALU_DEC  = 4'd5,
        ALU_AND  = 4'd6,
        ALU_OR   = 4'd7
    } alu_op_e;

    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_y;
    logic              z_q;
    logic              done_q;

    always_comb begin
        bus = '0;
        case (dp.bus_ld)
            4'd0:    bus = dp.dm_rdata;
            4'd1:    bus = dp.im_rdata;
            4'd2:    bus = rf[R_PC];
            4'd3:    bus = rf[R_DR];
            4'd4:    bus = rf[R_AC];
            4'd5:    bus = rf[R_R1];
            4'd6:    bus = rf[R_R2];
            4'd7:    bus = rf[R_R3];
            4'd8:    bus = rf[R_RI];
            4'd9:    bus = rf[R_RJ];
            4'd10:   bus = rf[R_RK];
            4'd11:   bus = rf[R_RN];
            4'd12:   bus = rf[R_TR];
            4'd13:   bus = rf[R_AR];
            default: bus = '0;
        endcase
    end

    // Everything wraps at DATA_W bits; the multiply keeps only the low half.
    always_comb begin
        alu_a = rf[R_AC];
        alu_y = alu_a;
        case (alu_op_e'(dp.alu_mode))
            ALU_PASS: alu_y = bus;
            ALU_ADD:  alu_y = alu_a + bus;
            ALU_SUB:  alu_y = alu_a - bus;
            ALU_MUL:  alu_y = alu_a * bus;
            ALU_INC:  alu_y = alu_a + ONE;
            ALU_DEC:  alu_y = alu_a - ONE;
            ALU_AND:  alu_y = alu_a & bus;
            ALU_OR:   alu_y = alu_a | bus;
            default:  alu_y = alu_a;
        endcase
    end

    // Later assignments win, so inc, then load, then clear gives clr > write_en > inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            z_q <= 1'b0;
        end else if (!done_q) begin
            case (dp.inc)
                2'b01:   rf[R_PC] <= rf[R_PC] + ONE;
                2'b10:   rf[R_RI] <= rf[R_RI] + ONE;
                2'b11:   rf[R_RJ] <= rf[R_RJ] + ONE;
                default: ;
            endcase
            for (int i = 0; i < NREG; i++) begin
                if (dp.write_en[i]) begin
                    rf[i] <= (i == R_AC) ? alu_y : bus;
                end
            end
            if (dp.clr[0]) rf[R_AC] <= '0;
            if (dp.clr[1]) rf[R_RI] <= '0;
            if (dp.clr[2]) rf[R_RJ] <= '0;
            if (dp.clr[0]) begin
                z_q <= 1'b1;
            end else if (dp.write_en[R_AC]) begin
                z_q <= (alu_y == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (dp.end_op) begin
            done_q <= 1'b1;
        end
    end

    assign dp.ir       = rf[R_IR][7:0];
    assign dp.z        = z_q;
    assign dp.dm_addr  = ADDR_W'(rf[R_AR]);
    assign dp.dm_wdata = rf[R_AC];
    assign dp.im_addr  = ADDR_W'(rf[R_PC]);
    assign dp.done     = done_q;
    // Write strobes are also held off while reset is asserted.
    assign dp.dm_we    = dp.dm_wr & ~done_q & rst_n;
    assign dp.im_we    = dp.im_wr & ~done_q & rst_n;

endmodule

// File: tb/tb_matmul_datapath.sv
// Randomized bench for matmul_datapath against a register-level behavioural model,
// plus directed fetch, ALU/Z, priority, store and end-of-program scenarios.
module tb_matmul_datapath;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int MASK   = 255;

    localparam logic [12:0] WE_AR = 13'h0001;
    localparam logic [12:0] WE_IR = 13'h0004;
    localparam logic [12:0] WE_AC = 13'h0010;
    localparam logic [12:0] WE_R1 = 13'h0020;
    localparam logic [12:0] WE_RI = 13'h0100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    matmul_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dp_if ();

    matmul_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp    (dp_if.slave)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model state: AR PC IR DR AC R1 R2 R3 RI RJ RK RN TR
    int m_reg [13];
    int m_z;
    int m_done;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int modelBus(input int src, input int dm, input int im);
        case (src)
            0:       return dm;
            1:       return im;
            2:       return m_reg[1];
            13:      return m_reg[0];
            14, 15:  return 0;
            default: return m_reg[src];
        endcase
    endfunction

    function automatic int modelAlu(input int mode, input int a, input int b);
        case (mode)
            0:       return b;
            1:       return (a + b) & MASK;
            2:       return (a - b) & MASK;
            3:       return (a * b) & MASK;
            4:       return (a + 1) & MASK;
            5:       return (a - 1) & MASK;
            6:       return a & b;
            7:       return a | b;
            default: return a;
        endcase
    endfunction

    function automatic void modelReset();
        foreach (m_reg[i]) m_reg[i] = 0;
        m_z    = 0;
        m_done = 0;
    endfunction

    function automatic void modelStep(input logic [3:0] bus_ld, input logic [12:0] we,
                                      input logic [1:0] inc, input logic [2:0] clr,
                                      input logic [3:0] mode, input logic end_op,
                                      input int dm, input int im);
        int b;
        int y;
        int inc_target;
        int nxt [13];
        if (!m_done) begin
            b = modelBus(int'(bus_ld), dm, im);
            y = modelAlu(int'(mode), m_reg[4], b);
            inc_target = (inc == 2'b01) ? 1 : (inc == 2'b10) ? 8 : (inc == 2'b11) ? 9 : -1;
            for (int i = 0; i < 13; i++) begin
                if ((i == 4 && clr[0]) || (i == 8 && clr[1]) || (i == 9 && clr[2]))
                    nxt[i] = 0;
                else if (we[i])
                    nxt[i] = (i == 4) ? y : b;
                else if (i == inc_target)
                    nxt[i] = (m_reg[i] + 1) & MASK;
                else
                    nxt[i] = m_reg[i];
            end
            if (clr[0])     m_z = 1;
            else if (we[4]) m_z = (y == 0) ? 1 : 0;
            m_reg = nxt;
        end
        if (end_op) m_done = 1;
    endfunction

    task automatic checkState(input string tag);
        checkOutput({tag, ".ir"},       32'(dp_if.ir),       32'(m_reg[2]));
        checkOutput({tag, ".z"},        32'(dp_if.z),        32'(m_z));
        checkOutput({tag, ".dm_addr"},  32'(dp_if.dm_addr),  32'(m_reg[0]));
        checkOutput({tag, ".dm_wdata"}, 32'(dp_if.dm_wdata), 32'(m_reg[4]));
        checkOutput({tag, ".im_addr"},  32'(dp_if.im_addr),  32'(m_reg[1]));
        checkOutput({tag, ".done"},     32'(dp_if.done),     32'(m_done));
    endtask

    // Drives one control word, checks the combinational outputs before the edge,
    // then checks the registered state just after it.
    task automatic applyStimulus(input string tag, input logic [3:0] bus_ld,
                                 input logic [12:0] we, input logic [1:0] inc,
                                 input logic [2:0] clr, input logic [3:0] mode,
                                 input logic dm_wr, input logic im_wr, input logic end_op,
                                 input logic [7:0] dm, input logic [7:0] im);
        dp_if.bus_ld   = bus_ld;
        dp_if.write_en = we;
        dp_if.inc      = inc;
        dp_if.clr      = clr;
        dp_if.alu_mode = mode;
        dp_if.dm_wr    = dm_wr;
        dp_if.im_wr    = im_wr;
        dp_if.end_op   = end_op;
        dp_if.dm_rdata = dm;
        dp_if.im_rdata = im;
        #1;
        checkOutput({tag, ".pre.dm_we"}, 32'(dp_if.dm_we), 32'(dm_wr && !m_done));
        checkOutput({tag, ".pre.im_we"}, 32'(dp_if.im_we), 32'(im_wr && !m_done));
        @(posedge clk);
        modelStep(bus_ld, we, inc, clr, mode, end_op, int'(dm), int'(im));
        #1;
        checkState(tag);
    endtask

    task automatic randomWord(input string tag);
        logic [2:0] clr;
        clr = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
        applyStimulus(tag, 4'($urandom), 13'($urandom) & 13'($urandom), 2'($urandom), clr,
                      4'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                      8'($urandom), 8'($urandom));
    endtask

    // Asserts reset between edges with write requests active, holds it across an edge.
    task automatic doReset(input string tag);
        dp_if.dm_wr    = 1'b1;
        dp_if.im_wr    = 1'b1;
        dp_if.write_en = 13'($urandom);
        dp_if.end_op   = 1'($urandom);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkState({tag, ".async"});
        checkOutput({tag, ".dm_we"}, 32'(dp_if.dm_we), 32'(0));
        checkOutput({tag, ".im_we"}, 32'(dp_if.im_we), 32'(0));
        @(posedge clk);
        #1;
        checkState({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dp_if.bus_ld   = 4'($urandom);
        dp_if.write_en = 13'($urandom);
        dp_if.inc      = 2'($urandom);
        dp_if.clr      = 3'($urandom);
        dp_if.alu_mode = 4'($urandom);
        dp_if.dm_wr    = 1'b1;
        dp_if.im_wr    = 1'b1;
        dp_if.end_op   = 1'b0;
        dp_if.dm_rdata = 8'($urandom);
        dp_if.im_rdata = 8'($urandom);
        #1;
        doReset("reset");
        checkOutput("reset.pc", 32'(dp_if.im_addr), 32'(0));

        applyStimulus("fetch", 4'd1, WE_IR, 2'b01, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);
        checkOutput("fetch.ir_const", 32'(dp_if.ir), 32'(1));
        checkOutput("fetch.pc_const", 32'(dp_if.im_addr), 32'(1));

        applyStimulus("ld_ac5", 4'd0, WE_AC, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'd5, 8'h00);
        applyStimulus("ld_r15", 4'd0, WE_R1, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'd5, 8'h00);
        applyStimulus("sub",    4'd5, WE_AC, 2'b00, 3'b000, 4'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("sub.ac_const", 32'(dp_if.dm_wdata), 32'(0));
        checkOutput("sub.z_const",  32'(dp_if.z), 32'(1));
        applyStimulus("ld_r17",  4'd0, WE_R1, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'd7, 8'h00);
        applyStimulus("ld_ac40", 4'd0, WE_AC, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'd40, 8'h00);
        applyStimulus("mul",     4'd5, WE_AC, 2'b00, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("mul.ac_const", 32'(dp_if.dm_wdata), 32'(24));
        checkOutput("mul.z_const",  32'(dp_if.z), 32'(0));

        applyStimulus("ld_riff", 4'd0, WE_RI, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
        applyStimulus("inc_ri",  4'd0, 13'h0, 2'b10, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus("rd_ri",   4'd8, WE_AC, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("wrap.ri_const", 32'(dp_if.dm_wdata), 32'(0));
        applyStimulus("ld_riff2", 4'd0, WE_RI, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
        applyStimulus("prio",     4'd0, WE_RI, 2'b10, 3'b010, 4'd0, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00);
        applyStimulus("rd_ri2",   4'd8, WE_AC, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("prio.ri_const", 32'(dp_if.dm_wdata), 32'(0));

        applyStimulus("ld_ar", 4'd0, WE_AR, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
        applyStimulus("ld_ac", 4'd0, WE_AC, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h2A, 8'h00);
        applyStimulus("store", 4'd15, 13'h0, 2'b00, 3'b000, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("store.dm_we_const",    32'(dp_if.dm_we), 32'(1));
        checkOutput("store.dm_addr_const",  32'(dp_if.dm_addr), 32'(8'h10));
        checkOutput("store.dm_wdata_const", 32'(dp_if.dm_wdata), 32'(8'h2A));

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 49) == 0) doReset("midreset");
            else randomWord("rand");
        end

        randomWord("pre_end");
        applyStimulus("end", 4'($urandom), 13'($urandom), 2'($urandom), 3'b000, 4'($urandom),
                      1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
        checkOutput("end.done_const", 32'(dp_if.done), 32'(1));
        applyStimulus("blocked", 4'd0, 13'h1FFF, 2'b01, 3'b111, 4'd1, 1'b1, 1'b1, 1'b0,
                      8'h5A, 8'hA5);
        checkOutput("blocked.dm_we_const", 32'(dp_if.dm_we), 32'(0));
        for (int i = 0; i < 20; i++) randomWord("after_end");

        doReset("final_reset");
        checkOutput("final_reset.done_const", 32'(dp_if.done), 32'(0));
        randomWord("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
